// File: rtl/leaf_mu_sink.sv
//------------------------------------------------------------------------------
// leaf_mu_sink : realigns a 1-bit left-shifted word stream into a FWFT FIFO,
//                with accepted-word count and optional XOR checksum.
// Optional feature macro: LEAF_MU_SINK_CHKSUM_EN (checksum register present).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module leaf_mu_sink #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           count,
   output logic [WIDTH-1:0]           checksum
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [LW-1:0]    level_q;
   logic [CNT_W-1:0] count_q;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] stored;
   logic             unused_lsb;

   // Handshake depends only on registered occupancy, never on out_ready.
   assign in_ready  = (level_q != LW'(DEPTH));
   assign out_valid = (level_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign stored    = {1'b0, in_data[WIDTH-1:1]};
   assign unused_lsb = in_data[0];

   assign out_data = out_valid ? mem[rd_ptr] : '0;
   assign level    = level_q;
   assign count    = count_q;

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= stored;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= '0;
         count_q <= '0;
      end else if (clear) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + AW'(1);
            count_q <= count_q + CNT_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

`ifdef LEAF_MU_SINK_CHKSUM_EN
   logic [WIDTH-1:0] checksum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum_q <= '0;
      end else if (clear) begin
         checksum_q <= '0;
      end else if (push) begin
         checksum_q <= checksum_q ^ stored;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_leaf_mu_sink.sv
//------------------------------------------------------------------------------
// tb_leaf_mu_sink : scoreboard bench for leaf_mu_sink (CNT_W=4 to reach wrap).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_leaf_mu_sink;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       level;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] checksum;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] sb_q[$];
   int               m_cnt;
   logic [WIDTH-1:0] m_cks;

   leaf_mu_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .count(count), .checksum(checksum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_cnt = 0;
      m_cks = '0;
   endtask

   // Compare all outputs against the model, then advance one clock and
   // update the model from the inputs that were presented on that edge.
   task automatic step();
      logic [WIDTH-1:0] w;
      logic             p, o;
      chk("in_ready",  {31'b0, in_ready},  {31'b0, sb_q.size() != DEPTH});
      chk("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() != 0});
      chk("out_data",  out_data, (sb_q.size() != 0) ? sb_q[0] : 32'h0);
      chk("level",     {29'b0, level}, sb_q.size());
      chk("count",     {28'b0, count}, m_cnt);
      chk("checksum",  checksum, m_cks);
      p = in_valid && (sb_q.size() < DEPTH);
      o = out_ready && (sb_q.size() > 0);
      @(posedge clk);
      if (clear) begin
         model_reset();
      end else begin
         if (o) void'(sb_q.pop_front());
         if (p) begin
            w = {1'b0, in_data[WIDTH-1:1]};
            sb_q.push_back(w);
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
`ifdef LEAF_MU_SINK_CHKSUM_EN
            m_cks = m_cks ^ w;
`endif
         end
      end
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] fill [4];
      fill[0] = 32'h8000_0001; fill[1] = 32'h0000_0002;
      fill[2] = 32'hFFFF_FFFF; fill[3] = 32'h0000_0004;

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Single word
      in_valid = 1'b1; in_data = 32'h0000_0246;
      step();
      in_valid = 1'b0;
      chk("single_data", out_data, 32'h0000_0123);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_empty", {31'b0, out_valid}, 32'h0);
      step();

      // Fill to full from a cleared state
      clear = 1'b1; step(); clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = fill[i];
         step();
      end
      in_data = 32'h5555_5555;
      step(); step();
      in_valid = 1'b0;
      chk("full_level", {29'b0, level}, 32'd4);
      chk("full_count", {28'b0, count}, 32'd4);
`ifdef LEAF_MU_SINK_CHKSUM_EN
      chk("full_cks", checksum, 32'h3FFF_FFFC);
`else
      chk("full_cks", checksum, 32'h0);
`endif
      out_ready = 1'b1;
      chk("drain0", out_data, 32'h4000_0000);
      repeat (4) step();
      out_ready = 1'b0;
      step();

      // Concurrent push/pop from level 2 across pointer wrap
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = $urandom; step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom; step();
      end
      chk("conc_level", {29'b0, level}, 32'd2);
      in_valid = 1'b0;
      repeat (3) step();
      out_ready = 1'b0;

      // Clear collision at level 3
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom; step();
      end
      clear = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD_BEEE;
      step();
      clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("clr_level", {29'b0, level}, 32'd0);
      chk("clr_count", {28'b0, count}, 32'd0);
      step();
      in_valid = 1'b1; in_data = 32'h0000_0A0A; step();
      in_valid = 1'b0; out_ready = 1'b1;
      chk("clr_next", out_data, 32'h0000_0505);
      repeat (2) step();
      out_ready = 1'b0;

      // Counter wrap with CNT_W=4
      clear = 1'b1; step(); clear = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = $urandom; step();
      end
      chk("cnt_wrap", {28'b0, count}, 32'd1);
      out_ready = 1'b0; in_data = $urandom;
      step();
      in_valid = 1'b0;
      step();

      // Async reset mid-cycle at level 2
      chk("pre_rst_level", {29'b0, level}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_out_data",  out_data, 32'h0);
      chk("rst_level",     {29'b0, level}, 32'h0);
      chk("rst_count",     {28'b0, count}, 32'h0);
      chk("rst_checksum",  checksum, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
